// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC and assembles 32-bit little-endian words from a byte-wide memory port.
// Define ICACHE_EN to add a direct-mapped one-word-per-line instruction cache in front of the byte path.
module if_fetch #(
  parameter int unsigned        ADDR_W     = 32,
  parameter int unsigned        INST_W     = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
  parameter int unsigned        IC_INDEX_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              stall_in,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_byte,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0] if_inst,
  output logic              if_stall_req
);

  typedef enum logic [2:0] {
    B0   = 3'd0,
    B1   = 3'd1,
    B2   = 3'd2,
    B3   = 3'd3,
    HOLD = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [23:0]         buf_q, buf_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                if_valid_q, if_valid_d;
  logic [ADDR_W-1:0]   if_pc_q, if_pc_d;
  logic [INST_W-1:0]   if_inst_q, if_inst_d;
  logic                stall_req_q, stall_req_d;

  logic [1:0]          byte_idx;
  logic [ADDR_W-1:0]   pc_inc;
  logic [ADDR_W-1:0]   jump_tgt;
  logic [INST_W-1:0]   fetched_word;
  logic                hit_cur;
  logic                hit_inc;
  logic [INST_W-1:0]   hit_word;

  assign byte_idx     = state_q[1:0];
  assign pc_inc       = pc_q + ADDR_W'(4);
  assign jump_tgt     = jump_addr & ~ADDR_W'(3);
  assign fetched_word = {mem_byte, buf_q};

`ifdef ICACHE_EN
  localparam int unsigned IC_LINES = 1 << IC_INDEX_W;
  localparam int unsigned TAG_W    = ADDR_W - IC_INDEX_W - 2;

  logic [IC_LINES-1:0]   ic_valid_q;
  logic [TAG_W-1:0]      ic_tag_q  [IC_LINES];
  logic [INST_W-1:0]     ic_data_q [IC_LINES];
  logic [IC_INDEX_W-1:0] idx_cur, idx_inc;
  logic                  fill_en;

  assign idx_cur  = pc_q[IC_INDEX_W+1:2];
  assign idx_inc  = pc_inc[IC_INDEX_W+1:2];
  assign hit_cur  = ic_valid_q[idx_cur] && (ic_tag_q[idx_cur] == pc_q[ADDR_W-1:IC_INDEX_W+2]);
  assign hit_inc  = ic_valid_q[idx_inc] && (ic_tag_q[idx_inc] == pc_inc[ADDR_W-1:IC_INDEX_W+2]);
  assign hit_word = ic_data_q[idx_cur];
  // The line is written on the same edge the freshly fetched word is presented.
  assign fill_en  = rdy && !jump_en && (state_q == B3) && mem_req_q && mem_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ic_valid_q <= '0;
    end else if (fill_en) begin
      ic_valid_q[idx_cur] <= 1'b1;
    end
  end

  // NOTE: only the valid bits are reset; tag/data stay reset-free so they map onto plain RAM.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      ic_tag_q[idx_cur]  <= pc_q[ADDR_W-1:IC_INDEX_W+2];
      ic_data_q[idx_cur] <= fetched_word;
    end
  end
`else
  assign hit_cur  = 1'b0;
  assign hit_inc  = 1'b0;
  assign hit_word = '0;
`endif

  // NOTE: every _d takes its hold value first, so no branch can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_d       = buf_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    if_valid_d  = if_valid_q;
    if_pc_d     = if_pc_q;
    if_inst_d   = if_inst_q;
    stall_req_d = stall_req_q;

    if (jump_en) begin
      // Redirect beats everything: in-flight bytes, a cache hit and a same-cycle consume.
      pc_d        = jump_tgt;
      state_d     = B0;
      buf_d       = '0;
      if_valid_d  = 1'b0;
      mem_req_d   = 1'b0;
      stall_req_d = 1'b1;
    end else if (state_q == HOLD) begin
      if (!stall_in) begin
        pc_d        = pc_inc;
        state_d     = B0;
        buf_d       = '0;
        if_valid_d  = 1'b0;
        stall_req_d = 1'b1;
        mem_req_d   = !hit_inc;
        mem_addr_d  = pc_inc;
      end
    end else if (!mem_req_q) begin
      if ((state_q == B0) && hit_cur) begin
        if_valid_d  = 1'b1;
        if_pc_d     = pc_q;
        if_inst_d   = hit_word;
        state_d     = HOLD;
        stall_req_d = 1'b0;
      end else begin
        mem_req_d   = 1'b1;
        mem_addr_d  = pc_q + ADDR_W'(byte_idx);
        stall_req_d = 1'b1;
      end
    end else if (mem_ack) begin
      case (state_q)
        B0:      buf_d[7:0]   = mem_byte;
        B1:      buf_d[15:8]  = mem_byte;
        B2:      buf_d[23:16] = mem_byte;
        default: ;
      endcase
      if (state_q == B3) begin
        if_valid_d  = 1'b1;
        if_pc_d     = pc_q;
        if_inst_d   = fetched_word;
        state_d     = HOLD;
        mem_req_d   = 1'b0;
        stall_req_d = 1'b0;
      end else begin
        state_d    = state_e'(state_q + 3'd1);
        mem_addr_d = pc_q + ADDR_W'(byte_idx) + ADDR_W'(1);
      end
    end
  end

  // NOTE: sequential state uses <= so every register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= B0;
      pc_q        <= RESET_PC;
      buf_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      if_valid_q  <= 1'b0;
      if_pc_q     <= '0;
      if_inst_q   <= '0;
      stall_req_q <= 1'b0;
    end else if (rdy) begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_q       <= buf_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      if_valid_q  <= if_valid_d;
      if_pc_q     <= if_pc_d;
      if_inst_q   <= if_inst_d;
      stall_req_q <= stall_req_d;
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_addr     = mem_addr_q;
  assign if_valid     = if_valid_q;
  assign if_pc        = if_pc_q;
  assign if_inst      = if_inst_q;
  assign if_stall_req = stall_req_q;

endmodule
